user_module_check_decoder: RTL and testbench
============================================

USER_MODULE_CHECK_DECODER -- requirements
Module: user_module_check_decoder

Interface
REQ-001 SHALL have parameter ERRCNT_W, default 4: width of the saturating error counter.
REQ-002 SHALL have port io_in[0], input, 1 bit: clock, rising edge.
REQ-003 SHALL have port io_in[1], input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port io_in[2], input, 1 bit: rx_bit, serial frame bit, LSB first.
REQ-005 SHALL have port io_in[3], input, 1 bit: rx_valid, qualifies rx_bit on the clock edge.
REQ-006 SHALL have port io_in[4], input, 1 bit: frame_start, begins a new frame.
REQ-007 SHALL have port io_in[5], input, 1 bit: nib_sel, selects the low (0) or high (1) data nibble for display.
REQ-008 SHALL have port io_in[6], input, 1 bit: show_cnt, shows the error count instead of data.
REQ-009 SHALL have port io_in[7], input, 1 bit: cnt_clr, clears the error counter.
REQ-010 SHALL have port io_out[0], output, 1 bit: ready, high in IDLE.
REQ-011 SHALL have port io_out[1], output, 1 bit: done, one-cycle pulse at frame completion.
REQ-012 SHALL have port io_out[2], output, 1 bit: err0, c0 mismatch of the last frame.
REQ-013 SHALL have port io_out[3], output, 1 bit: err1, c1 mismatch of the last frame.
REQ-014 SHALL have port io_out[7:4], output, 4 bits: display nibble.

Function
REQ-015 SHALL define the check function on data d[7:0] as follows: c0 = d0 ^ (~d1&d3) ^ (d1&d2) ^ (d3&d4); c1 = d5 ^ (d2&~d4) ^ (d2&d6) ^ (d4&d7).
REQ-016 SHALL frame 10 bits: d0..d7, then received c0, then received c1.
REQ-017 SHALL use the FSM states IDLE, DATA, CHECK and REPORT.
REQ-018 SHALL transition IDLE->DATA on frame_start=1 and clear the bit index.
REQ-019 SHALL, in DATA, accept rx_bit into d[idx] on each cycle with rx_valid=1, and go to CHECK after the 8th accepted bit.
REQ-020 SHALL, in CHECK, accept the two received check bits with rx_valid=1, and go to REPORT after the 2nd.
REQ-021 SHALL, in REPORT, last exactly one cycle, assert done, latch err0/err1 = computed XOR received, then return to IDLE.
REQ-022 SHALL hold state and index in DATA/CHECK while rx_valid=0, with no timeout.
REQ-023 SHALL restart at DATA with index 0 when frame_start=1 in DATA or CHECK, discarding partial data; frame_start takes priority over rx_valid in the same cycle.
REQ-024 SHALL ignore rx_valid while in IDLE or REPORT.
REQ-025 SHALL update the data register only on accepted data bits; the last complete frame's data SHALL remain displayed until the next REPORT.
REQ-026 SHALL increment the error counter by 1 in REPORT when err0|err1, and saturate it at 2^ERRCNT_W-1.
REQ-027 SHALL clear the counter on cnt_clr=1; cnt_clr SHALL win over a simultaneous increment.
REQ-028 SHALL drive io_out[7:4] as: show_cnt=1 -> counter[3:0]; else nib_sel=0 -> data[3:0]; else data[7:4]. The display path is combinational from registers.
REQ-029 SHALL assert done at the edge following acceptance of c1 (latency 1 cycle), with err0/err1 valid from that same cycle and held until the next REPORT.

Reset
REQ-030 SHALL, on reset, set state=IDLE, index=0, data=0x00, err0=err1=0, done=0, counter=0, and ready=1 on the next cycle.
REQ-031 SHALL, on reset mid-frame, abandon the frame without asserting done and without counting an error.

Structure
REQ-032 SHALL place the FSM state enum, FRAME_DATA_BITS=8 and FRAME_CHECK_BITS=2 in shared package check_code_pkg.
REQ-033 SHALL use one combinational sub-module, check_bits_calc (d[7:0] -> c0,c1), reusable by the encoder side.

Verification
REQ-034 SHALL check: frame 0xA5, c0=1, c1=0 -> done pulse, err0=0, err1=0, display 0x5 (nib_sel=0) and 0xA (nib_sel=1).
REQ-035 SHALL check: frame 0xFF, c0=0, c1=1 -> err0=1, err1=0, counter=1.
REQ-036 SHALL check: 4 data bits, then frame_start, then full frame 0x20, c0=0, c1=1 -> single done, no error, display high nibble 0x2.
REQ-037 SHALL check: rx_valid gaps of 3 cycles between every bit of frame 0x01, c0=1, c1=0 -> done exactly once, no error.
REQ-038 SHALL check: 20 erroneous frames -> counter reads 15 (saturated); cnt_clr coincident with a REPORT error -> counter=0.
REQ-039 SHALL check: reset asserted after the 6th data bit -> ready=1, done never pulses, counter and display read 0.

Source files
------------

// File: rtl/check_code_pkg.sv
// Shared definitions for the check-code frame decoder and its encoder-side companions.
package check_code_pkg;

  localparam int FRAME_DATA_BITS  = 8;
  localparam int FRAME_CHECK_BITS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CHECK  = 2'd2,
    REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/check_bits_calc.sv
// Combinational check-bit generator: data byte in, (c0, c1) out.
module check_bits_calc (
  input  logic [7:0] d,
  output logic       c0,
  output logic       c1
);

  assign c0 = d[0] ^ (~d[1] & d[3]) ^ (d[1] & d[2]) ^ (d[3] & d[4]);
  assign c1 = d[5] ^ (d[2] & ~d[4]) ^ (d[2] & d[6]) ^ (d[4] & d[7]);

endmodule

// File: rtl/user_module_check_decoder.sv
// Serial check-code frame decoder: collects 8 data bits plus 2 check bits LSB first,
// reports per-frame check mismatches and keeps a saturating error count.
module user_module_check_decoder
  import check_code_pkg::*;
#(
  parameter int ERRCNT_W = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [2:0]          LAST_DATA_IDX  = 3'(FRAME_DATA_BITS - 1);
  localparam logic [2:0]          LAST_CHECK_IDX = 3'(FRAME_CHECK_BITS - 1);
  localparam logic [ERRCNT_W-1:0] CNT_MAX        = '1;

  logic clk, rst, rx_bit, rx_valid, frame_start, nib_sel, show_cnt, cnt_clr;

  assign clk         = io_in[0];
  assign rst         = io_in[1];
  assign rx_bit      = io_in[2];
  assign rx_valid    = io_in[3];
  assign frame_start = io_in[4];
  assign nib_sel     = io_in[5];
  assign show_cnt    = io_in[6];
  assign cnt_clr     = io_in[7];

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          asm_q, asm_d;
  logic                rc0_q, rc0_d;
  logic [7:0]          data_q, data_d;
  logic                err0_q, err0_d;
  logic                err1_q, err1_d;
  logic [ERRCNT_W-1:0] cnt_q, cnt_d;

  logic calc_c0, calc_c1;

  check_bits_calc u_calc (
    .d  (asm_q),
    .c0 (calc_c0),
    .c1 (calc_c1)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    rc0_d   = rc0_q;
    data_d  = data_q;
    err0_d  = err0_q;
    err1_d  = err1_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end

      DATA: begin
        if (frame_start) begin
          idx_d = '0;
        end else if (rx_valid) begin
          asm_d[idx_q] = rx_bit;
          if (idx_q == LAST_DATA_IDX) begin
            state_d = CHECK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      CHECK: begin
        if (frame_start) begin
          state_d = DATA;
          idx_d   = '0;
        end else if (rx_valid) begin
          if (idx_q == LAST_CHECK_IDX) begin
            // Results are latched on c1 acceptance so they appear together with done.
            state_d = REPORT;
            idx_d   = '0;
            data_d  = asm_q;
            err0_d  = calc_c0 ^ rc0_q;
            err1_d  = calc_c1 ^ rx_bit;
          end else begin
            rc0_d = rx_bit;
            idx_d = idx_q + 3'd1;
          end
        end
      end

      REPORT: begin
        state_d = IDLE;
        if ((err0_q | err1_q) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + ERRCNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      cnt_q   <= cnt_d;
    end
  end

  // The in-flight frame bits carry no meaning outside DATA/CHECK, so they skip reset.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
    rc0_q <= rc0_d;
  end

  logic [3:0] cnt_nib;
  logic [3:0] disp;

  always_comb begin
    cnt_nib = 4'(cnt_q);
    if (show_cnt) begin
      disp = cnt_nib;
    end else if (nib_sel) begin
      disp = data_q[7:4];
    end else begin
      disp = data_q[3:0];
    end
  end

  assign io_out = {disp, err1_q, err0_q, (state_q == REPORT), (state_q == IDLE)};

endmodule

// File: tb/tb_user_module_check_decoder.sv
// Randomized and directed bench for the check-code frame decoder with a frame-level model.
module tb_user_module_check_decoder;

  localparam int ERRCNT_W = 4;
  localparam int CNT_MAX  = (1 << ERRCNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxb = 1'b0;
  logic       vld = 1'b0;
  logic       fs  = 1'b0;
  logic       nib = 1'b0;
  logic       shw = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] io_out;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  user_module_check_decoder #(.ERRCNT_W(ERRCNT_W)) dut (
    .io_in  ({clr, shw, nib, fs, vld, rxb, rst, clk}),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit [1:0] ref_chk(input bit [7:0] d);
    bit c0, c1;
    c0 = d[0] ^ (~d[1] & d[3]) ^ (d[1] & d[2]) ^ (d[3] & d[4]);
    c1 = d[5] ^ (d[2] & ~d[4]) ^ (d[2] & d[6]) ^ (d[4] & d[7]);
    return {c1, c0};
  endfunction

  // Frame-level model: a list of collected bits, a "report pending" flag and results.
  bit        m_coll = 0;
  bit        m_rep  = 0;
  int        m_n    = 0;
  bit [9:0]  m_bits = '0;
  bit [7:0]  m_data = '0;
  bit        m_e0 = 0, m_e1 = 0;
  int        m_cnt = 0;
  bit        chk_en = 0;

  task automatic model_step();
    int nc;
    bit [1:0] cc;
    if (rst) begin
      m_coll = 0; m_rep = 0; m_n = 0;
      m_data = '0; m_e0 = 0; m_e1 = 0; m_cnt = 0;
      chk_en = 1;
    end else begin
      nc = m_cnt;
      if (m_rep && (m_e0 || m_e1)) nc = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (clr) nc = 0;
      if (m_rep) begin
        m_rep = 0;
      end else if (fs) begin
        m_coll = 1; m_n = 0;
      end else if (m_coll && vld) begin
        m_bits[m_n] = rxb;
        m_n++;
        if (m_n == 10) begin
          m_coll = 0; m_rep = 1; m_n = 0;
          m_data = m_bits[7:0];
          cc = ref_chk(m_bits[7:0]);
          m_e0 = cc[0] ^ m_bits[8];
          m_e1 = cc[1] ^ m_bits[9];
        end
      end
      m_cnt = nc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [3:0] ed;
    logic [7:0] exp8;
    @(negedge clk);
    if (chk_en) begin
      ed = shw ? 4'(m_cnt) : (nib ? m_data[7:4] : m_data[3:0]);
      exp8 = {ed, m_e1, m_e0, m_rep, !(m_coll || m_rep)};
      chk("cycle_model", io_out, exp8);
      if (io_out[1] === 1'b1) done_seen++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    fs = 1; tick(); fs = 0;
  endtask

  task automatic send_bits(input bit [9:0] b, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      vld = 1; rxb = b[i];
      tick();
      vld = 0; rxb = 0;
      if (i < n - 1) for (int g = 0; g < gap; g++) tick();
    end
  endtask

  // Returns just after c1 has been accepted, i.e. inside the REPORT cycle.
  task automatic send_frame(input bit [7:0] d, input bit c0, input bit c1, input int gap);
    tick();
    start();
    send_bits({c1, c0, d}, 10, gap);
  endtask

  initial begin
    int d0;
    bit [7:0] rd;
    bit [1:0] rc;
    bit flip0, flip1;

    rst = 1; tick(); tick(); rst = 0;
    chk("reset_out", io_out, 8'h01);
    shw = 1; #1;
    chk("reset_cnt", io_out[7:4], 4'h0);
    shw = 0;

    send_frame(8'hA5, 1'b1, 1'b0, 0);
    chk("a5_done", io_out[1], 1'b1);
    chk("a5_err", io_out[3:2], 2'b00);
    chk("a5_lo", io_out[7:4], 4'h5);
    nib = 1; #1;
    chk("a5_hi", io_out[7:4], 4'hA);
    nib = 0;

    send_frame(8'hFF, 1'b0, 1'b1, 0);
    chk("ff_err", io_out[3:2], 2'b01);
    tick();
    shw = 1; #1;
    chk("ff_cnt", io_out[7:4], 4'h1);
    shw = 0;

    d0 = done_seen;
    tick(); start();
    send_bits(10'h00B, 4, 0);
    send_frame(8'h20, 1'b0, 1'b1, 0);
    nib = 1; #1;
    chk("restart_err", io_out[3:2], 2'b00);
    chk("restart_hi", io_out[7:4], 4'h2);
    nib = 0;
    tick(); tick();
    chk("restart_one_done", done_seen - d0, 1);

    d0 = done_seen;
    send_frame(8'h01, 1'b1, 1'b0, 3);
    chk("gap_err", io_out[3:2], 2'b00);
    tick(); tick();
    chk("gap_one_done", done_seen - d0, 1);

    clr = 1; tick(); clr = 0;
    for (int k = 0; k < 20; k++) send_frame(8'hFF, 1'b0, 1'b1, 0);
    tick();
    shw = 1; #1;
    chk("sat_cnt", io_out[7:4], 4'hF);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    chk("clr_err_present", io_out[2], 1'b1);
    clr = 1; tick(); clr = 0; #1;
    chk("clr_wins", io_out[7:4], 4'h0);
    shw = 0;

    d0 = done_seen;
    tick(); start();
    send_bits(10'h03F, 6, 0);
    rst = 1; tick(); rst = 0;
    chk("midrst_ready", io_out[0], 1'b1);
    chk("midrst_lo", io_out[7:4], 4'h0);
    nib = 1; #1;
    chk("midrst_hi", io_out[7:4], 4'h0);
    nib = 0; shw = 1; #1;
    chk("midrst_cnt", io_out[7:4], 4'h0);
    shw = 0;
    send_bits(10'h3FF, 4, 0);
    tick(); tick();
    chk("midrst_no_done", done_seen - d0, 0);

    for (int k = 0; k < 30; k++) begin
      rd = 8'($urandom);
      rc = ref_chk(rd);
      flip0 = ($urandom_range(0, 2) == 0);
      flip1 = ($urandom_range(0, 2) == 0);
      nib = 1'($urandom); shw = 1'($urandom);
      send_frame(rd, rc[0] ^ flip0, rc[1] ^ flip1, $urandom_range(0, 2));
      chk("rand_frame_done", io_out[1], 1'b1);
      chk("rand_frame_err", io_out[3:2], {flip1, flip0});
    end

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 599) == 0);
      fs  = ($urandom_range(0, 29) == 0);
      vld = 1'($urandom);
      rxb = 1'($urandom);
      nib = 1'($urandom);
      shw = 1'($urandom);
      clr = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; fs = 0; vld = 0; clr = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
